// File: rtl/bmem_arbiter.sv
// Two-port line-request arbiter onto a beat-wide banked memory; macro BMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
// Latency: grant in IDLE, bmem_read/bmem_write one cycle later; resp_valid pulses one cycle after the last beat is accepted.
// Backpressure: issue and write beats stall while bmem_ready is low; read beats are taken only on rvalid with a matching raddr.
module bmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4,
    localparam int LINE_W = BEAT_W * BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_read,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LINE_W-1:0] req_wdata0,
    input  logic [LINE_W-1:0] req_wdata1,
    output logic [1:0]        resp_valid,
    output logic [LINE_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wline_q, wline_d;
    logic              owner_q, owner_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] bmem_addr_q, bmem_addr_d;
    logic              bmem_read_q, bmem_read_d;
    logic              bmem_write_q, bmem_write_d;
    logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;
    logic [1:0]        req_any;
    logic              gnt;
`ifndef BMEM_ARB_FIXED_PRIO_EN
    logic              last_grant_q, last_grant_d;
`endif

    always_comb begin
        req_any  = req_read | req_write;
        gnt      = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wline_d  = wline_q;
        owner_d  = owner_q;
        rdata_d  = rdata_q;
`ifndef BMEM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_any) begin
                    if (&req_any) begin
`ifdef BMEM_ARB_FIXED_PRIO_EN
                        gnt = 1'b0;
`else
                        gnt = ~last_grant_q;
`endif
                    end else begin
                        gnt = req_any[1];
                    end
`ifndef BMEM_ARB_FIXED_PRIO_EN
                    last_grant_d = gnt;
`endif
                    owner_d = gnt;
                    addr_d  = (gnt ? req_addr1 : req_addr0) & ADDR_MASK;
                    wline_d = gnt ? req_wdata1 : req_wdata0;
                    cnt_d   = '0;
                    // a port raising both read and write is served as a write
                    state_d = req_write[gnt] ? WR_BURST : RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (bmem_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bmem_rvalid && (bmem_raddr == addr_q)) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (cnt_q == CNT_W'(k)) rdata_d[BEAT_W*k +: BEAT_W] = bmem_rdata;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // outputs are registered from the next-state view so they line up with the state they describe
        bmem_read_d  = (state_d == RD_ISSUE);
        bmem_write_d = (state_d == WR_BURST);
        bmem_addr_d  = (bmem_read_d || bmem_write_d) ? addr_d : '0;
        bmem_wdata_d = '0;
        if (bmem_write_d) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_d == CNT_W'(k)) bmem_wdata_d = wline_d[BEAT_W*k +: BEAT_W];
            end
        end
        resp_valid_d = (state_d == RESP) ? {owner_d, ~owner_d} : 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wline_q      <= '0;
            owner_q      <= 1'b0;
            rdata_q      <= '0;
            resp_valid_q <= 2'b00;
            bmem_addr_q  <= '0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
`ifndef BMEM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wline_q      <= wline_d;
            owner_q      <= owner_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            bmem_addr_q  <= bmem_addr_d;
            bmem_read_q  <= bmem_read_d;
            bmem_write_q <= bmem_write_d;
            bmem_wdata_q <= bmem_wdata_d;
`ifndef BMEM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule
